mfe_param_window: RTL

//  3x3 neighbourhood filter engine, parametrised successor of the fixed 128x128 median engine.

---
 rtl/mfe_param_window.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mfe_param_window.sv
// 3x3 neighbourhood filter (median/min/max) over a 2**W_LOG2 x 2**H_LOG2 frame.
// Keeps three pre-sorted columns and fetches only the newly entering column per pixel.
module mfe_param_window #(
  parameter int W_LOG2 = 7,
  parameter int H_LOG2 = 7,
  parameter int DW     = 8,
  parameter int AW     = W_LOG2 + H_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [1:0]    mode,
  input  logic          border,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen,
  output logic          done
);

  localparam int CW = ((W_LOG2 > H_LOG2) ? W_LOG2 : H_LOG2) + 2;
  localparam int W  = 1 << W_LOG2;
  localparam int H  = 1 << H_LOG2;
  localparam logic signed [CW-1:0] ZERO_S = CW'(0);
  localparam logic signed [CW-1:0] W_S    = CW'(W);
  localparam logic signed [CW-1:0] H_S    = CW'(H);
  localparam logic signed [CW-1:0] XMAX_S = CW'(W - 1);
  localparam logic signed [CW-1:0] YMAX_S = CW'(H - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CSORT, EVAL, WRITE, DONE} state_e;

  state_e               state_q;
  logic signed [CW-1:0] x_q, y_q, cx_q;
  logic [1:0]           col_cnt_q, phase_q, mode_q;
  logic                 border_q;
  logic [2:0]           oob_q;
  logic [DW-1:0]        smp_q [3];
  logic [DW-1:0]        lo_q  [3];
  logic [DW-1:0]        mid_q [3];
  logic [DW-1:0]        hi_q  [3];
  logic [AW-1:0]        iaddr_q, addr_q;
  logic [DW-1:0]        data_q;
  logic                 busy_q, wen_q, done_q;

  logic signed [CW-1:0] ry;
  logic                 oob_now, req;
  logic [W_LOG2-1:0]    ax;
  logic [H_LOG2-1:0]    ay;
  logic [1:0]           prev_ph;
  logic [DW-1:0]        s_lo, s_mid, s_hi, result;

  function automatic logic [DW-1:0] mn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  // Address for the current fetch slot; out-of-frame reads without clamping hold the last address.
  always_comb begin
    ry      = y_q + CW'(phase_q) - CW'(1);
    oob_now = (ry < ZERO_S) || (ry >= H_S) || (cx_q < ZERO_S) || (cx_q >= W_S);
    if (cx_q < ZERO_S)   ax = '0;
    else if (cx_q >= W_S) ax = '1;
    else                  ax = cx_q[W_LOG2-1:0];
    if (ry < ZERO_S)      ay = '0;
    else if (ry >= H_S)   ay = '1;
    else                  ay = ry[H_LOG2-1:0];
    req     = (state_q == FETCH) && (phase_q != 2'd3) && (border_q || !oob_now);
    iaddr   = req ? {ay, ax} : iaddr_q;
    prev_ph = phase_q - 2'd1;
    s_lo    = mn(mn(smp_q[0], smp_q[1]), smp_q[2]);
    s_hi    = mx(mx(smp_q[0], smp_q[1]), smp_q[2]);
    s_mid   = med3(smp_q[0], smp_q[1], smp_q[2]);
    case (mode_q)
      2'b01:   result = mn(mn(lo_q[0], lo_q[1]), lo_q[2]);
      2'b10:   result = mx(mx(hi_q[0], hi_q[1]), hi_q[2]);
      default: result = med3(mx(mx(lo_q[0], lo_q[1]), lo_q[2]),
                             med3(mid_q[0], mid_q[1], mid_q[2]),
                             mn(mn(hi_q[0], hi_q[1]), hi_q[2]));
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cx_q      <= '0;
      col_cnt_q <= '0;
      phase_q   <= '0;
      mode_q    <= '0;
      border_q  <= 1'b0;
      oob_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        smp_q[i] <= '0;
        lo_q[i]  <= '0;
        mid_q[i] <= '0;
        hi_q[i]  <= '0;
      end
      iaddr_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      if (req) iaddr_q <= iaddr;
      case (state_q)
        IDLE: begin
          if (ready) begin
            mode_q    <= mode;
            border_q  <= border;
            x_q       <= '0;
            y_q       <= '0;
            cx_q      <= '1;
            col_cnt_q <= 2'd3;
            phase_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (phase_q != 2'd3) oob_q[phase_q] <= oob_now && !border_q;
          if (phase_q != 2'd0) smp_q[prev_ph] <= oob_q[prev_ph] ? '0 : idata;
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd3) state_q <= CSORT;
        end
        CSORT: begin
          lo_q[0]  <= lo_q[1];  lo_q[1]  <= lo_q[2];  lo_q[2]  <= s_lo;
          mid_q[0] <= mid_q[1]; mid_q[1] <= mid_q[2]; mid_q[2] <= s_mid;
          hi_q[0]  <= hi_q[1];  hi_q[1]  <= hi_q[2];  hi_q[2]  <= s_hi;
          if (col_cnt_q > 2'd1) begin
            col_cnt_q <= col_cnt_q - 2'd1;
            cx_q      <= cx_q + CW'(1);
            state_q   <= FETCH;
          end else begin
            state_q <= EVAL;
          end
        end
        EVAL: begin
          data_q  <= result;
          addr_q  <= {y_q[H_LOG2-1:0], x_q[W_LOG2-1:0]};
          wen_q   <= 1'b1;
          state_q <= WRITE;
        end
        // Advance raster position; a new row restarts the three-column preload.
        WRITE: begin
          if (x_q == XMAX_S) begin
            x_q <= '0;
            if (y_q == YMAX_S) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              y_q       <= y_q + CW'(1);
              cx_q      <= '1;
              col_cnt_q <= 2'd3;
              state_q   <= FETCH;
            end
          end else begin
            x_q       <= x_q + CW'(1);
            cx_q      <= x_q + CW'(2);
            col_cnt_q <= 2'd1;
            state_q   <= FETCH;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign addr    = addr_q;
  assign data_wr = data_q;
  assign wen     = wen_q;
  assign done    = done_q;

endmodule
